// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, ALU op encodings, control bundle and decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    alu_op_e alu_op;
    logic    jal;
    logic    jalr;
    logic    branch;
    logic    bne;
    logic    mem_ren;
    logic    mem_wen;
    logic    mem_to_reg;
    logic    reg_wen;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both forms.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic f7b5, input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d     = '0;
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    case (inst[6:0])
      OPC_LUI: begin
        d.ctrl.alu_src = 1'b1;
        d.ctrl.alu_op  = ALU_PASSB;
        d.ctrl.reg_wen = 1'b1;
        d.imm          = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d.ctrl.alu_src = 1'b1;
        d.ctrl.reg_wen = 1'b1;
        d.imm          = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.ctrl.jal     = 1'b1;
        d.ctrl.reg_wen = 1'b1;
        d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        d.ctrl.jalr    = 1'b1;
        d.ctrl.alu_src = 1'b1;
        d.ctrl.reg_wen = 1'b1;
        d.imm          = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.bne    = inst[12];
        d.ctrl.alu_op = ALU_SUB;
        d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LOAD: begin
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_ren    = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_wen    = 1'b1;
        d.imm             = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        d.ctrl.alu_src = 1'b1;
        d.ctrl.mem_wen = 1'b1;
        d.imm          = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OPIMM: begin
        d.ctrl.alu_src = 1'b1;
        d.ctrl.alu_op  = alu_sel(inst[14:12], inst[30], 1'b0);
        d.ctrl.reg_wen = 1'b1;
        d.imm          = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP: begin
        d.ctrl.alu_op  = alu_sel(inst[14:12], inst[30], 1'b1);
        d.ctrl.reg_wen = 1'b1;
      end
      default: ;
    endcase
    // Non-writing instructions carry rd=0 so EX forwarding never matches their imm bits.
    d.rd = d.ctrl.reg_wen ? inst[11:7] : 5'd0;
    return d;
  endfunction

endpackage

// File: rtl/riscv_id_stage_hz_if.sv
// ID/EX pipeline register bundle; master is the decode stage, slave is execute.
interface riscv_id_stage_hz_if #(
  parameter int unsigned XLEN = 32
);
  import riscv_pkg::*;

  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  ctrl_t           ex_ctrl;

  modport master (
    output ex_valid, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_ctrl
  );

  modport slave (
    input ex_valid, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_ctrl
  );

endinterface

// File: rtl/riscv_hazard_unit.sv
// Combinational load-use detector and source-operand usage decode.
module riscv_hazard_unit import riscv_pkg::*; #(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       if_valid,
  input  logic       ex_valid,
  input  logic       ex_mem_ren,
  input  logic [4:0] ex_rd,
  output logic       load_use,
  output logic       rs1_used,
  output logic       rs2_used
);

  // A load in EX whose destination feeds an operand of the instruction in ID forces a bubble.
  always_comb begin
    rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    load_use = LOAD_USE_STALL && ex_valid && ex_mem_ren && (ex_rd != 5'd0) &&
               ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2)) && if_valid;
  end

endmodule

// File: rtl/riscv_id_stage_hz.sv
// Decode stage: decode, register read with WB bypass, hazard bubbles, deferred flush, perf counters.
module riscv_id_stage_hz import riscv_pkg::*; #(
  parameter int unsigned XLEN           = 32,
  parameter bit          BYPASS_WB      = 1'b1,
  parameter bit          LOAD_USE_STALL = 1'b1,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_ready,
  input  logic              ex_stall,
  input  logic              flush,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  riscv_id_stage_hz_if.master ex,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_bubble_cnt
);

  dec_t            dec;
  logic            load_use;
  logic            rs1_used;
  logic            rs2_used;
  logic            pend_flush;
  logic            kill;
  logic            bubble;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign dec    = decode(if_inst);
  assign rf_rs1 = dec.rs1;
  assign rf_rs2 = dec.rs2;

  riscv_hazard_unit #(
    .LOAD_USE_STALL (LOAD_USE_STALL)
  ) u_hazard (
    .opcode     (if_inst[6:0]),
    .rs1        (dec.rs1),
    .rs2        (dec.rs2),
    .if_valid   (if_valid),
    .ex_valid   (ex.ex_valid),
    .ex_mem_ren (ex.ex_ctrl.mem_ren),
    .ex_rd      (ex.ex_rd),
    .load_use   (load_use),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used)
  );

  // Usage flags only matter inside the hazard unit; kept as nets for debug visibility.
  logic unused_rs_used;
  assign unused_rs_used = rs1_used ^ rs2_used;

  // Operand select: x0 reads zero, then same-cycle WB bypass, then register file.
  always_comb begin
    op1 = rf_rs1_data;
    op2 = rf_rs2_data;
    if (BYPASS_WB && wb_wen && wb_rd == dec.rs1) op1 = wb_data;
    if (BYPASS_WB && wb_wen && wb_rd == dec.rs2) op2 = wb_data;
    if (dec.rs1 == 5'd0) op1 = '0;
    if (dec.rs2 == 5'd0) op2 = '0;
  end

  // Flush wins over load-use, so a killed cycle never counts as a bubble; id_ready ignores flush.
  assign id_ready = !ex_stall && !load_use;
  assign kill     = flush || pend_flush;
  assign bubble   = !ex_stall && !kill && load_use;

  // ID/EX register: hold on stall, kill on (deferred) flush or bubble, otherwise load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_flush     <= 1'b0;
      ex.ex_valid    <= 1'b0;
      ex.ex_rd       <= '0;
      ex.ex_rs1      <= '0;
      ex.ex_rs2      <= '0;
      ex.ex_rs1_data <= '0;
      ex.ex_rs2_data <= '0;
      ex.ex_imm      <= '0;
      ex.ex_pc       <= '0;
      ex.ex_ctrl     <= '0;
    end else begin
      pend_flush <= ex_stall && (pend_flush || flush);
      if (!ex_stall) begin
        ex.ex_rs1      <= dec.rs1;
        ex.ex_rs2      <= dec.rs2;
        ex.ex_rs1_data <= op1;
        ex.ex_rs2_data <= op2;
        ex.ex_imm      <= XLEN'($signed(dec.imm));
        ex.ex_pc       <= if_pc;
        if (kill || load_use) begin
          ex.ex_valid <= 1'b0;
          ex.ex_ctrl  <= '0;
          ex.ex_rd    <= '0;
        end else begin
          ex.ex_valid <= if_valid;
          ex.ex_ctrl  <= if_valid ? dec.ctrl : '0;
          ex.ex_rd    <= dec.rd;
        end
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (ex_stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (bubble && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_id_stage_hz.sv
// Scoreboard bench for riscv_id_stage_hz: stimulus pushes model results, a monitor pops and compares.
module tb_riscv_id_stage_hz;
  import riscv_pkg::*;

  localparam int unsigned PW     = 4;
  localparam int unsigned CNTMAX = 15;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_stall, flush, wb_wen, id_ready;
  logic [31:0] if_inst, if_pc, rf_rs1_data, rf_rs2_data, wb_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd;
  logic [PW-1:0] perf_stall_cnt, perf_bubble_cnt;
  logic [31:0] rfmem [32];

  always #5 clk = ~clk;

  riscv_id_stage_hz_if #(.XLEN(32)) exif ();

  riscv_id_stage_hz #(
    .XLEN (32), .BYPASS_WB (1'b1), .LOAD_USE_STALL (1'b1), .PERF_W (PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .id_ready        (id_ready),
    .ex_stall        (ex_stall),
    .flush           (flush),
    .rf_rs1          (rf_rs1),
    .rf_rs2          (rf_rs2),
    .rf_rs1_data     (rf_rs1_data),
    .rf_rs2_data     (rf_rs2_data),
    .wb_wen          (wb_wen),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .ex              (exif),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  // Register file contents never change, so a WB write leaves them stale.
  assign rf_rs1_data = rfmem[rf_rs1];
  assign rf_rs2_data = rfmem[rf_rs2];

  typedef struct packed {
    logic v; logic [4:0] rd, rs1, rs2; logic [31:0] d1, d2, imm, pc;
    logic mr, mw, rw; logic [31:0] sc, bc;
  } exp_t;

  typedef struct packed {
    logic [4:0] rd, rs1, rs2; logic u1, u2, mr, mw, rw; logic [31:0] imm;
  } dm_t;

  exp_t        q[$];
  exp_t        m;
  logic        m_pend;
  logic        last_rdy;
  logic [31:0] g_pc;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ISA-level view of an instruction word.
  function automatic dm_t tb_dec(input logic [31:0] w);
    dm_t d;
    logic [6:0] op;
    op    = w[6:0];
    d     = '0;
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    d.u1  = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    d.u2  = op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    d.mr  = (op == OPC_LOAD);
    d.mw  = (op == OPC_STORE);
    d.rw  = op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP};
    d.rd  = d.rw ? w[11:7] : 5'd0;
    case (op)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: d.imm = {{20{w[31]}}, w[31:20]};
      OPC_STORE:  d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      OPC_BRANCH: d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: d.imm = {w[31:12], 12'b0};
      OPC_JAL:    d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:    d.imm = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] rs, input logic we,
                                       input logic [4:0] wrd, input logic [31:0] wd);
    if (rs == 5'd0) return 32'd0;
    if (we && wrd == rs) return wd;
    return rfmem[rs];
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd8, rs1, 3'b010, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0:       w[6:0] = OPC_LOAD;
      1:       w[6:0] = OPC_OP;
      2:       w[6:0] = OPC_OPIMM;
      3:       w[6:0] = OPC_STORE;
      4:       w[6:0] = OPC_BRANCH;
      5:       w[6:0] = OPC_LUI;
      default: w[6:0] = OPC_JAL;
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Drive one cycle at the negedge, check id_ready and read addresses, push the post-edge state.
  task automatic step(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic st, input logic fl, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd);
    dm_t  d;
    exp_t n;
    logic lu, rdy, kill;
    @(negedge clk);
    rst = r; if_valid = v; if_inst = inst; if_pc = pc; ex_stall = st; flush = fl;
    wb_wen = we; wb_rd = wrd; wb_data = wd;
    d   = tb_dec(inst);
    lu  = m.v && m.mr && m.rd != 5'd0 && ((d.u1 && m.rd == d.rs1) || (d.u2 && m.rd == d.rs2)) && v;
    rdy = !st && !lu;
    #1;
    chk("id_ready", 32'(id_ready), 32'(rdy));
    chk("rf_rs1", 32'(rf_rs1), 32'(d.rs1));
    chk("rf_rs2", 32'(rf_rs2), 32'(d.rs2));
    n = m;
    if (r) begin
      n      = '0;
      m_pend = 1'b0;
    end else if (st) begin
      if (n.sc < CNTMAX) n.sc = n.sc + 1;
      m_pend = m_pend || fl;
    end else begin
      kill   = fl || m_pend;
      m_pend = 1'b0;
      n.rs1 = d.rs1; n.rs2 = d.rs2; n.imm = d.imm; n.pc = pc;
      n.d1  = opnd(d.rs1, we, wrd, wd);
      n.d2  = opnd(d.rs2, we, wrd, wd);
      if (kill || lu) begin
        n.v = 1'b0; n.rd = 5'd0; n.mr = 1'b0; n.mw = 1'b0; n.rw = 1'b0;
        if (!kill && n.bc < CNTMAX) n.bc = n.bc + 1;
      end else begin
        n.v = v; n.rd = d.rd; n.mr = v && d.mr; n.mw = v && d.mw; n.rw = v && d.rw;
      end
    end
    m        = n;
    last_rdy = rdy;
    q.push_back(n);
  endtask

  task automatic issue(input logic [31:0] inst, input logic st, input logic fl);
    step(1'b0, 1'b1, inst, g_pc, st, fl, 1'b0, 5'd0, 32'd0);
    g_pc = g_pc + 4;
  endtask

  // Monitor: after every active edge compare the ID/EX register against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", 32'(exif.ex_valid), 32'(e.v));
        chk("ex_rd", 32'(exif.ex_rd), 32'(e.rd));
        chk("ex_rs1", 32'(exif.ex_rs1), 32'(e.rs1));
        chk("ex_rs2", 32'(exif.ex_rs2), 32'(e.rs2));
        chk("ex_rs1_data", exif.ex_rs1_data, e.d1);
        chk("ex_rs2_data", exif.ex_rs2_data, e.d2);
        chk("ex_imm", exif.ex_imm, e.imm);
        chk("ex_pc", exif.ex_pc, e.pc);
        chk("mem_ren", 32'(exif.ex_ctrl.mem_ren), 32'(e.mr));
        chk("mem_wen", 32'(exif.ex_ctrl.mem_wen), 32'(e.mw));
        chk("reg_wen", 32'(exif.ex_ctrl.reg_wen), 32'(e.rw));
        if (!e.v) chk("ctrl_cleared", 32'(exif.ex_ctrl), 32'd0);
        chk("perf_stall_cnt", 32'(perf_stall_cnt), e.sc);
        chk("perf_bubble_cnt", 32'(perf_bubble_cnt), e.bc);
      end
    end
  end

  initial begin
    logic [31:0] cur_inst, cur_pc;
    logic        cur_v;
    for (int i = 0; i < 32; i++) rfmem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    rfmem[0] = 32'h0BAD_0000;
    rst = 1'b1; if_valid = 1'b0; if_inst = NOP; if_pc = 32'd0; ex_stall = 1'b0; flush = 1'b0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    m = '0; m_pend = 1'b0; last_rdy = 1'b1; g_pc = 32'h100;

    // Reset for two cycles.
    repeat (2) step(1'b1, 1'b0, NOP, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Load-use: one bubble, then the held add enters.
    issue(lw(5'd5, 5'd1), 1'b0, 1'b0);
    step(1'b0, 1'b1, add(5'd6, 5'd5, 5'd2), g_pc, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    issue(add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);

    // WB bypass over a stale register file, then x0 ignores a WB to x0.
    step(1'b0, 1'b1, add(5'd8, 5'd7, 5'd7), g_pc, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, add(5'd9, 5'd0, 5'd3), g_pc, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    issue(lw(5'd0, 5'd1), 1'b0, 1'b0);
    issue(add(5'd10, 5'd0, 5'd0), 1'b0, 1'b0);

    // Flush together with load-use: kill wins, no bubble counted.
    issue(lw(5'd5, 5'd1), 1'b0, 1'b0);
    step(1'b0, 1'b1, add(5'd6, 5'd5, 5'd2), g_pc, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    issue(add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);

    // Flush during a 3-cycle stall is applied on the first unstalled edge.
    issue(add(5'd11, 5'd1, 5'd2), 1'b0, 1'b0);
    issue(add(5'd12, 5'd3, 5'd4), 1'b1, 1'b1);
    issue(add(5'd12, 5'd3, 5'd4), 1'b1, 1'b0);
    issue(add(5'd12, 5'd3, 5'd4), 1'b1, 1'b0);
    issue(add(5'd12, 5'd3, 5'd4), 1'b0, 1'b0);
    issue(add(5'd13, 5'd3, 5'd4), 1'b0, 1'b0);

    // Reset while stalled with a pending flush clears everything.
    issue(add(5'd14, 5'd1, 5'd1), 1'b1, 1'b1);
    step(1'b1, 1'b1, NOP, g_pc, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    issue(add(5'd14, 5'd1, 5'd1), 1'b0, 1'b0);

    // Counter saturation.
    repeat (20) issue(NOP, 1'b1, 1'b0);
    issue(add(5'd15, 5'd2, 5'd3), 1'b0, 1'b0);

    // Randomized traffic; IF holds its instruction while not accepted.
    cur_inst = NOP; cur_pc = 32'h2000; cur_v = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (last_rdy || !cur_v) begin
        cur_inst = rnd_inst();
        cur_pc   = cur_pc + 4;
        cur_v    = ($urandom_range(0, 7) != 0);
      end
      step(($urandom_range(0, 63) == 0), cur_v, cur_inst, cur_pc, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_id_stage_hz.md
# riscv_id_stage_hz

Parametrised decode stage with a built-in hazard unit for the pipelined RISC-V core. It sits between the fetch stage and the execute stage. Each cycle it decodes one instruction, reads the register file, and registers operands and control into the ID/EX pipeline register. Unlike a plain decode register, it adds a valid bit, load-use bubble insertion, WB→ID register bypass, deferred flush under downstream stall, and saturating performance counters.

## Interface
Parameters:
- XLEN, 32, datapath/register width
- BYPASS_WB, 1, 1 = forward WB write data into ID operand read
- LOAD_USE_STALL, 1, 1 = detect load-use hazard and insert bubble; 0 = no detection
- PERF_W, 32, width of each performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  ID accepts this cycle; IF must hold when 0
- ex_stall  in  1  EX/MEM cannot accept; ID/EX register holds
- flush  in  1  branch/jump redirect; kill the instruction entering ID/EX
- rf_rs1, rf_rs2  out  5  register file read addresses
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data
- wb_wen  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- ex_valid  out  1  ID/EX holds a live instruction
- ex_rd, ex_rs1, ex_rs2  out  5  register addresses, used by EX forwarding
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN  operands, immediate, PC
- ex_ctrl  out  CTRL_W  packed control bundle
- perf_stall_cnt, perf_bubble_cnt  out  PERF_W  saturating counters

## Operation
- Decode uses the shared decoder sub-module. rs1_used is false for LUI, AUIPC and JAL. rs2_used is true only for R-type, STORE and BRANCH.
- Operand select, per source:
  - address 0 → 0
  - else if BYPASS_WB && wb_wen && wb_rd==rs → wb_data
  - else rf data
- load_use = LOAD_USE_STALL && ex_valid && ex_ctrl.mem_ren && ex_rd!=0 && ((rs1_used && ex_rd==rs1) || (rs2_used && ex_rd==rs2)) && if_valid.
- id_ready = !ex_stall && !load_use.
- pend_flush is an internal flag. It sets when flush && ex_stall. It clears on the first cycle with !ex_stall.
- ID/EX update priority on each posedge:
  1. rst: all registers to 0.
  2. ex_stall: hold all ID/EX registers.
  3. flush || pend_flush: ex_valid←0, ex_ctrl←0, ex_rd←0. Data fields load normally.
  4. load_use: bubble. ex_valid←0, ex_ctrl←0, ex_rd←0. IF holds the instruction.
  5. Otherwise: ex_valid←if_valid. Control is cleared when !if_valid. All fields load.
- perf_stall_cnt increments on every cycle with ex_stall. perf_bubble_cnt increments on every load_use bubble. Both saturate at all-ones. Neither counter wraps.

## Timing
- Reset: every output register and counter is 0, and pend_flush is 0.
- id_ready is combinational, with no added latency.
- Latency: an instruction accepted at edge N is visible on the ex_* outputs after edge N.
- A load-use bubble costs exactly one cycle. On the next cycle the loaded value arrives through EX forwarding, because ex_valid is 0 and the hazard clears.
- Simultaneous events:
  - flush with load_use: flush wins. No bubble is counted, and id_ready stays 0 that cycle.
  - flush with ex_stall: deferred via pend_flush. The kill applies on the first unstalled edge.
  - WB write to the same rs in the same cycle: the bypass value is used.
- A rst asserted mid-stall or mid-pend_flush clears everything on that edge.

## Structure
- The shared package `riscv_pkg` holds:
  - the opcode constants
  - the ctrl_t packed struct (alu_src, alu_op[3:0], jal, jalr, branch, bne, mem_ren, mem_wen, mem_to_reg, reg_wen; CTRL_W = 13)
  - the ALU op encodings
- Sub-module `riscv_hazard_unit` is combinational and produces load_use, rs1_used and rs2_used. All sequential state stays in the top module.

## Test plan
- Reset: hold rst 2 cycles → all ex_* outputs 0, both counters 0, id_ready=1.
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2` → one bubble (ex_valid=0), id_ready=0 for one cycle, add enters EX next cycle, perf_bubble_cnt=1.
- WB bypass: wb_wen=1, wb_rd=7, wb_data=0xDEADBEEF, with rf stale for an ID instruction reading x7 → ex_rs1_data=0xDEADBEEF.
- x0 handling: instruction reads x0 while wb_rd=0, wb_data=0x1234 → ex_rs1_data=0. `lw x0` does not trigger load-use.
- Deferred flush: flush pulse while ex_stall=1 for 3 cycles → ex_* held during the stall, then ex_valid=0 on the first unstalled edge, perf_stall_cnt=3.
- Saturation, with PERF_W=4: 20 ex_stall cycles → perf_stall_cnt=15 and stays at 15.
